// File: rtl/seq_squarer_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_squarer_if
// Brief    : Operand-in / square-out handshake bundle for seq_squarer.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_squarer_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   y;
    logic                 busy;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_squarer.sv
`default_nettype none
// ============================================================================
// Module   : seq_squarer
// Brief    : Sequential shift-add squarer, fixed WIDTH-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module seq_squarer #(
    parameter int WIDTH       = 8,
    parameter int SIGNED_MODE = 0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    seq_squarer_if.slave  bus
);

    localparam int             c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_y;

    logic [WIDTH-1:0]     w_mag;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_accept;
    logic                 w_last;

    // Magnitude taken modulo 2^WIDTH, so the most negative operand maps to 2^(WIDTH-1).
    generate
        if (SIGNED_MODE != 0) begin : g_signed
            assign w_mag = bus.a[WIDTH-1] ? ({WIDTH{1'b0}} - bus.a) : bus.a;
        end else begin : g_unsigned
            assign w_mag = bus.a;
        end
    endgenerate

    assign w_accept   = (r_state == c_IDLE) && bus.in_valid;
    assign w_last     = (r_cnt == c_LAST);
    assign w_addend   = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    assign w_acc_next = r_mplier[0] ? (r_acc + w_addend) : r_acc;
    assign bus.y      = r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.in_valid)  w_state_next = c_CALC;
            c_CALC:  if (w_last)        w_state_next = c_DONE;
            c_DONE:  if (bus.out_ready) w_state_next = c_IDLE;
            default:                    w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            c_IDLE: bus.in_ready = 1'b1;
            c_CALC: bus.busy     = 1'b1;
            c_DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    // Datapath; y is only rewritten on the final step so it persists across IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_y      <= '0;
        end else if (w_accept) begin
            r_mcand  <= w_mag;
            r_mplier <= w_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == c_CALC) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_y <= w_acc_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_squarer.md
SEQ_SQUARER -- requirements
Module: seq_squarer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter SIGNED_MODE, default 0, where 0 means operand is unsigned and 1 means operand is two's complement.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the operand on a is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept an operand.
REQ-007 The block SHALL have port a, input, WIDTH bits, the operand to be squared.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning y holds a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the downstream consumer accepts y.
REQ-010 The block SHALL have port y, output, 2*WIDTH bits, the square of a.
REQ-011 The block SHALL have port busy, output, 1 bit, high in CALC or DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-014 An input handshake occurs when in_valid and in_ready are both high at a rising edge; on that edge the block SHALL:
- latch the magnitude of a (|a| when SIGNED_MODE=1, else a) into the multiplicand and multiplier registers;
- clear the 2*WIDTH-bit accumulator and the bit counter;
- enter CALC.
REQ-015 In SIGNED_MODE=1, |a| SHALL be computed in WIDTH bits treated as unsigned, so a = -2^(WIDTH-1) yields magnitude 2^(WIDTH-1).
REQ-016 Each CALC cycle SHALL perform one shift-add step:
- if multiplier bit 0 is 1, add (multiplicand << counter) to the accumulator;
- shift the multiplier right by 1;
- increment the counter.
REQ-017 After exactly WIDTH CALC cycles the block SHALL enter DONE, with y equal to the full 2*WIDTH-bit square and no truncation.
REQ-018 Latency SHALL be fixed at WIDTH cycles: for a handshake at edge T, out_valid rises at edge T+WIDTH, independent of the operand value (including 0).
REQ-019 The accumulator width of 2*WIDTH bits SHALL never overflow, since the maximum result is (2^WIDTH-1)^2.
REQ-020 In DONE, y and out_valid SHALL hold stable for as long as out_ready is low (backpressure).
REQ-021 When out_valid and out_ready are both high at an edge, the block SHALL return to IDLE, and in_ready SHALL be high in the following cycle.
REQ-022 A new operand SHALL NOT be accepted in the same cycle as an output handshake, giving a minimum initiation interval of WIDTH+1 cycles.
REQ-023 in_valid and changes on a while busy SHALL be ignored and SHALL NOT corrupt the result in flight.
REQ-024 y SHALL retain the last result after leaving DONE, until the next DONE entry overwrites it.

Reset
REQ-025 While rst_n is low the block SHALL immediately, without waiting for clk, set:
- state to IDLE;
- in_ready to 1;
- out_valid, busy and y to 0;
- the accumulator, counter, multiplicand and multiplier registers to 0.
REQ-026 Assertion of rst_n during CALC or DONE SHALL abort the operation, and no result for that operand SHALL ever appear.
REQ-027 After rst_n deasserts, the block SHALL accept an operand at the first rising edge with in_valid high.

Verification
REQ-028 WIDTH=8, SIGNED_MODE=0, a=255 with a single-cycle in_valid and out_ready tied high -> out_valid rises exactly 8 edges later with y=16'd65025, and in_ready is high on the next cycle.
REQ-029 WIDTH=8, unsigned, a=0 and then a=1 -> y=0 and then y=1, each after exactly 8 cycles.
REQ-030 WIDTH=8, SIGNED_MODE=1, with inputs 8'h80 then 8'hFD then 8'h7F -> y=16384, then 9, then 16129.
REQ-031 Backpressure: hold out_ready low for 5 cycles after out_valid rises -> y and out_valid remain constant and in_ready stays low; after one out_ready pulse, out_valid falls and in_ready rises.
REQ-032 While busy, toggle in_valid and change a every cycle -> no extra handshake occurs and y equals the square of the originally latched operand.
REQ-033 Assert rst_n low mid-CALC (cycle 4 of 8) -> all outputs reach reset values without a clock edge; a fresh a=3 after release -> y=9 after 8 cycles.
REQ-034 WIDTH=3, unsigned, exhaustive sweep of a=0..7 -> y equals a*a for all eight values, each after 3 cycles.
